// File: rtl/serial_adder_ctrl_if.sv
// Handshake and bit-stream bundle between a requester and the serial adder controller.
// Controller owns the slave side; the requester or bench owns the master side.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             busy;
   logic             bit_valid;
   logic             bit_a;
   logic             bit_b;
   logic             bit_sum;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             done;

   modport master (
      output start, op_a, op_b, cin,
      input  busy, bit_valid, bit_a, bit_b, bit_sum, sum, cout, done
   );

   modport slave (
      input  start, op_a, op_b, cin,
      output busy, bit_valid, bit_a, bit_b, bit_sum, sum, cout, done
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: shifts operands out LSB first through a full-add
// built from a half-adder pair with a registered carry, and collects the sum.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; sum/cout hold the last result
//   S_SHIFT | one operand bit pair per cycle, WIDTH cycles in total
//   S_DONE  | one-cycle completion pulse; start ignored
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             in_shift;
   logic             bit_a;
   logic             bit_b;
   logic             bit_sum;
   logic             carry_nxt;
   logic             last_bit;

   assign in_shift  = (state_q == S_SHIFT);
   assign bit_a     = in_shift & a_q[0];
   assign bit_b     = in_shift & b_q[0];
   assign bit_sum   = bit_a ^ bit_b ^ (in_shift & carry_q);
   assign carry_nxt = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
   assign last_bit  = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               carry_d = bus.cin;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Widen by one so the new bit lands in the MSB even when WIDTH is 1.
            sum_d   = WIDTH'({bit_sum, sum_q} >> 1);
            carry_d = carry_nxt;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (last_bit) begin
               cout_d  = carry_nxt;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy      = (state_q == S_SHIFT) | (state_q == S_DONE);
   assign bus.bit_valid = in_shift;
   assign bus.done      = (state_q == S_DONE);
   assign bus.bit_a     = bit_a;
   assign bus.bit_b     = bit_b;
   assign bus.bit_sum   = bit_sum;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance driven from a vector
// table plus corner sequences, and a 1-bit instance for the degenerate width.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) b8 ();
   serial_adder_ctrl_if #(.WIDTH(1)) b1 ();

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Runs one 8-bit addition from an idle state and checks latency, stream and result.
   task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec, input string nm);
      int         lat;
      int         idx;
      logic [7:0] stream;
      @(negedge clk);
      b8.op_a = a; b8.op_b = b; b8.cin = ci; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      b8.op_a = ~a; b8.op_b = ~b; b8.cin = ~ci;
      lat = 0; idx = 0; stream = '0;
      while (!b8.done && lat < 40) begin
         if (b8.bit_valid && idx < 8) begin
            stream[idx] = b8.bit_sum;
            idx++;
         end
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'd8);
      chk({nm, " valid_bits"}, 32'(idx), 32'd8);
      chk({nm, " stream"}, 32'(stream), 32'(es));
      chk({nm, " sum"}, 32'(b8.sum), 32'(es));
      chk({nm, " cout"}, 32'(b8.cout), 32'(ec));
      chk({nm, " busy_in_done"}, 32'(b8.busy), 32'd1);
      @(negedge clk);
      chk({nm, " done_one_cycle"}, 32'(b8.done), 32'd0);
      chk({nm, " busy_after"}, 32'(b8.busy), 32'd0);
      chk({nm, " sum_hold"}, 32'(b8.sum), 32'(es));
   endtask

   task automatic do_add1(input logic a, input logic b, input logic ci,
                          input logic es, input logic ec, input string nm);
      int lat;
      int nvalid;
      @(negedge clk);
      b1.op_a = a; b1.op_b = b; b1.cin = ci; b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      lat = 0; nvalid = 0;
      while (!b1.done && lat < 10) begin
         if (b1.bit_valid) nvalid++;
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'd1);
      chk({nm, " valid_cycles"}, 32'(nvalid), 32'd1);
      chk({nm, " sum"}, 32'(b1.sum), 32'(es));
      chk({nm, " cout"}, 32'(b1.cout), 32'(ec));
      @(negedge clk);
      chk({nm, " done_one_cycle"}, 32'(b1.done), 32'd0);
      chk({nm, " valid_after"}, 32'(b1.bit_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ndone;
      int         lat;
      logic [7:0] dsum;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

      b8.start = 1'b0; b8.op_a = '0; b8.op_b = '0; b8.cin = 1'b0;
      b1.start = 1'b0; b1.op_a = '0; b1.op_b = '0; b1.cin = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle busy", 32'(b8.busy), 32'd0);
         chk("idle done", 32'(b8.done), 32'd0);
         chk("idle sum", 32'(b8.sum), 32'd0);
         chk("idle cout", 32'(b8.cout), 32'd0);
         chk("idle bit_a", 32'(b8.bit_a), 32'd0);
      end

      for (int i = 0; i < 7; i++)
         do_add8(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_sum, vecs[i].exp_cout,
                 $sformatf("vec%0d", i));

      // Second start at cycle 3 must be ignored.
      @(negedge clk);
      b8.op_a = 8'h05; b8.op_b = 8'h03; b8.cin = 1'b0; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      repeat (2) @(negedge clk);
      b8.op_a = 8'hAA; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      ndone = 0; dsum = '0;
      for (int i = 0; i < 14; i++) begin
         if (b8.done) begin
            ndone++;
            dsum = b8.sum;
         end
         @(negedge clk);
      end
      chk("ignore done_count", 32'(ndone), 32'd1);
      chk("ignore sum", 32'(dsum), 32'h08);
      do_add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_ignore");

      // start held high through DONE: accepted only once back in IDLE.
      @(negedge clk);
      b8.op_a = 8'h01; b8.op_b = 8'h01; b8.cin = 1'b0; b8.start = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!b8.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("held done_seen", 32'(b8.done), 32'd1);
      @(negedge clk);
      chk("held idle_gap", 32'(b8.busy), 32'd0);
      @(negedge clk);
      chk("held reaccept", 32'(b8.busy), 32'd1);
      b8.start = 1'b0;
      lat = 0;
      while (!b8.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("held second_sum", 32'(b8.sum), 32'h02);
      @(negedge clk);

      // Abort mid-SHIFT; cout=1 left by the previous add exposes a missing clear.
      do_add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "pre_abort");
      @(negedge clk);
      b8.op_a = 8'h55; b8.op_b = 8'h33; b8.cin = 1'b0; b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(b8.busy), 32'd0);
      chk("abort bit_valid", 32'(b8.bit_valid), 32'd0);
      chk("abort sum", 32'(b8.sum), 32'd0);
      chk("abort cout", 32'(b8.cout), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (b8.done) ndone++;
         if (i == 2) rst_n = 1'b1;
      end
      chk("abort no_done", 32'(ndone), 32'd0);
      do_add8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "post_abort");

      do_add1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "w1_111");
      do_add1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "w1_100");
      do_add1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "w1_101");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
